// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller, and the slave side is the datapath.
interface multicycle_ctrl_if #(
    parameter int ALUCTL_W = 3
);
    logic [5:0]          op;
    logic [5:0]          funct;
    logic                zero;
    logic                pcen;
    logic                memwrite;
    logic                irwrite;
    logic                regwrite;
    logic                iord;
    logic                memtoreg;
    logic                regdst;
    logic                alusrca;
    logic [1:0]          alusrcb;
    logic [1:0]          pcsrc;
    logic [ALUCTL_W-1:0] alucontrol;
    logic [3:0]          state;
    logic                illegal;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// It also contains the ALU decoder and the branch-qualified PC enable.
module multicycle_ctrl #(
    parameter int ALUCTL_W     = 3,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_ctrl_if.master      bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6, S_ALUWB  = 4'd7,
        S_BRANCH  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP  = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_reg, state_next, eff_state;
    logic       pcwrite, branch, bne_sel, illegal_op;
    logic       irwrite_raw, regwrite_raw, memwrite_raw, illegal_raw;
    logic [1:0] aluop;
    logic [2:0] alu_code;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        illegal_op = 1'b0;
        case (bus.op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal_op = 1'b0;
            default: illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW:   state_next = S_MEMADR;
                    OP_RTYPE:       state_next = S_EXEC;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_ADDI:        state_next = S_ADDIEX;
                    OP_J:           state_next = S_JUMP;
                    default:        state_next = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            // The IR is frozen after fetch, so op still selects load vs store here.
            S_MEMADR: state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Reset presents FETCH steering but with every write enable suppressed.
    always_comb begin
        eff_state    = reset ? S_FETCH : state_reg;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        bne_sel      = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.pcsrc    = 2'b00;
        aluop        = 2'b00;
        case (eff_state)
            S_FETCH:  begin irwrite_raw = 1'b1; pcwrite = 1'b1; bus.alusrcb = 2'b01; end
            S_DECODE: begin bus.alusrcb = 2'b11; illegal_raw = illegal_op; end
            S_MEMADR, S_ADDIEX: begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
            S_MEMRD:  bus.iord = 1'b1;
            S_MEMWB:  begin regwrite_raw = 1'b1; bus.memtoreg = 1'b1; end
            S_MEMWR:  begin bus.iord = 1'b1; memwrite_raw = 1'b1; end
            S_EXEC:   begin bus.alusrca = 1'b1; aluop = 2'b10; end
            S_ALUWB:  begin regwrite_raw = 1'b1; bus.regdst = 1'b1; end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_BRANCH: begin
                bus.alusrca = 1'b1;
                aluop       = 2'b01;
                bus.pcsrc   = 2'b01;
                branch      = 1'b1;
                bne_sel     = (bus.op == OP_BNE);
            end
            S_JUMP:   begin bus.pcsrc = 2'b10; pcwrite = 1'b1; end
            S_HALT:   illegal_raw = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        alu_code = 3'b010;
        case (aluop)
            2'b00: alu_code = 3'b010;
            2'b01: alu_code = 3'b110;
            default: begin
                case (bus.funct)
                    6'b100000: alu_code = 3'b010;
                    6'b100010: alu_code = 3'b110;
                    6'b100100: alu_code = 3'b000;
                    6'b100101: alu_code = 3'b001;
                    6'b101010: alu_code = 3'b111;
                    default:   alu_code = 3'b010;
                endcase
            end
        endcase
    end

    assign bus.pcen       = ~reset & (pcwrite | (branch & (bus.zero ^ bne_sel)));
    assign bus.irwrite    = ~reset & irwrite_raw;
    assign bus.regwrite   = ~reset & regwrite_raw;
    assign bus.memwrite   = ~reset & memwrite_raw;
    assign bus.illegal    = ~reset & illegal_raw;
    assign bus.alucontrol = ALUCTL_W'(alu_code);
    assign bus.state      = state_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance with illegal ops returning
// to FETCH, and one that parks in HALT, both driven by the same stimulus.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    int   wr_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALUCTL_W(3)) bus0 ();
    multicycle_ctrl_if #(.ALUCTL_W(3)) bus1 ();

    multicycle_ctrl #(.ALUCTL_W(3), .ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    multicycle_ctrl #(.ALUCTL_W(3), .ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [5:0] o, input logic [5:0] f);
        bus0.op = o;  bus1.op = o;
        bus0.funct = f; bus1.funct = f;
    endtask

    task automatic set_zero(input logic z);
        bus0.zero = z; bus1.zero = z;
        #1;
    endtask

    // Walks the R-type path from FETCH and checks the ALU code in EXECUTE.
    task automatic run_rtype(input logic [5:0] f, input logic [2:0] exp_alu);
        set_op(6'b000000, f);
        chk("r_fetch", 32'(bus0.state), 0);
        tick(); chk("r_decode", 32'(bus0.state), 1);
        tick(); chk("r_exec", 32'(bus0.state), 6);
        chk("r_alu", 32'(bus0.alucontrol), 32'(exp_alu));
        chk("r_exec_nowr", 32'(bus0.regwrite), 0);
        tick(); chk("r_aluwb", 32'(bus0.state), 7);
        chk("r_wb_rw", 32'({bus0.regwrite, bus0.regdst}), 3);
        tick();
    endtask

    // Branch: FETCH, DECODE, BRANCH with zero applied inside the BRANCH cycle.
    task automatic run_branch(input logic [5:0] o, input logic z, input logic exp_pcen);
        set_op(o, 6'b000000);
        set_zero(1'b0);
        chk("b_fetch", 32'(bus0.state), 0);
        tick(); chk("b_decode", 32'(bus0.state), 1);
        tick(); chk("b_branch", 32'(bus0.state), 8);
        set_zero(z);
        chk("b_pcen", 32'(bus0.pcen), 32'(exp_pcen));
        chk("b_pcsrc", 32'(bus0.pcsrc), 1);
        chk("b_alu", 32'(bus0.alucontrol), 3'b110);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        set_op(6'b000000, 6'b100000);
        bus0.zero = 1'b0; bus1.zero = 1'b0;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_state", 32'(bus0.state), 0);
            chk("rst_enables", 32'({bus0.pcen, bus0.irwrite, bus0.regwrite, bus0.memwrite, bus0.illegal}), 0);
            chk("rst_alusrcb", 32'(bus0.alusrcb), 1);
        end
        reset = 1'b0;
        #1;
        chk("first_fetch", 32'({bus0.irwrite, bus0.pcen}), 3);

        // R-type add, then the other funct codes
        run_rtype(6'b100000, 3'b010);
        chk("r_back_fetch", 32'(bus0.state), 0);
        run_rtype(6'b100010, 3'b110);
        run_rtype(6'b100100, 3'b000);
        run_rtype(6'b100101, 3'b001);
        run_rtype(6'b101010, 3'b111);
        run_rtype(6'b111000, 3'b010);

        // lw
        set_op(6'b100011, 6'b000000);
        chk("lw_fetch", 32'(bus0.state), 0);
        tick(); chk("lw_decode", 32'(bus0.state), 1);
        chk("lw_dec_alusrcb", 32'(bus0.alusrcb), 3);
        tick(); chk("lw_memadr", 32'(bus0.state), 2);
        chk("lw_adr_src", 32'({bus0.alusrca, bus0.alusrcb}), 3'b110);
        tick(); chk("lw_memrd", 32'(bus0.state), 3);
        chk("lw_iord", 32'(bus0.iord), 1);
        tick(); chk("lw_memwb", 32'(bus0.state), 4);
        chk("lw_wb", 32'({bus0.memtoreg, bus0.regwrite, bus0.regdst}), 3'b110);
        tick(); chk("lw_done", 32'(bus0.state), 0);

        // sw: count memwrite cycles across the instruction
        set_op(6'b101011, 6'b000000);
        wr_cnt = 0;
        chk("sw_fetch", 32'(bus0.state), 0);
        wr_cnt += int'(bus0.memwrite);
        tick(); chk("sw_decode", 32'(bus0.state), 1);
        wr_cnt += int'(bus0.memwrite);
        tick(); chk("sw_memadr", 32'(bus0.state), 2);
        wr_cnt += int'(bus0.memwrite);
        tick(); chk("sw_memwr", 32'(bus0.state), 5);
        chk("sw_iord", 32'(bus0.iord), 1);
        wr_cnt += int'(bus0.memwrite);
        tick(); chk("sw_done", 32'(bus0.state), 0);
        wr_cnt += int'(bus0.memwrite);
        chk("sw_memwrite_cycles", 32'(wr_cnt), 1);

        // Branches
        run_branch(6'b000100, 1'b0, 1'b0);
        run_branch(6'b000100, 1'b1, 1'b1);
        run_branch(6'b000101, 1'b0, 1'b1);
        run_branch(6'b000101, 1'b1, 1'b0);
        set_zero(1'b0);

        // addi
        set_op(6'b001000, 6'b000000);
        chk("addi_fetch", 32'(bus0.state), 0);
        tick(); chk("addi_decode", 32'(bus0.state), 1);
        tick(); chk("addi_ex", 32'(bus0.state), 9);
        chk("addi_ex_src", 32'({bus0.alusrca, bus0.alusrcb}), 3'b110);
        tick(); chk("addi_wb", 32'(bus0.state), 10);
        chk("addi_wb_rw", 32'({bus0.regwrite, bus0.regdst}), 2);
        tick();

        // j
        set_op(6'b000010, 6'b000000);
        chk("j_fetch", 32'(bus0.state), 0);
        tick(); chk("j_decode", 32'(bus0.state), 1);
        chk("j_dec_pcen", 32'(bus0.pcen), 0);
        tick(); chk("j_jump", 32'(bus0.state), 11);
        chk("j_pc", 32'({bus0.pcen, bus0.pcsrc}), 3'b110);
        tick(); chk("j_done", 32'(bus0.state), 0);

        // Illegal opcode on both instances
        set_op(6'b111111, 6'b000000);
        tick(); chk("ill_decode", 32'(bus0.state), 1);
        chk("ill_flag0", 32'(bus0.illegal), 1);
        chk("ill_flag1", 32'(bus1.illegal), 1);
        tick(); chk("ill_ret_fetch", 32'(bus0.state), 0);
        chk("ill_clear0", 32'(bus0.illegal), 0);
        chk("ill_halt", 32'(bus1.state), 15);
        chk("ill_halt_flag", 32'(bus1.illegal), 1);
        for (int i = 0; i < 3; i++) tick();
        chk("ill_halt_held", 32'(bus1.state), 15);
        chk("ill_halt_noen", 32'({bus1.pcen, bus1.irwrite, bus1.regwrite, bus1.memwrite}), 0);
        reset = 1'b1;
        tick(); chk("ill_reset0", 32'(bus0.state), 0);
        chk("ill_reset1", 32'(bus1.state), 0);
        chk("ill_reset_flag", 32'(bus1.illegal), 0);
        reset = 1'b0;
        #1;

        // Reset in MEMRD of a lw
        set_op(6'b100011, 6'b000000);
        wr_cnt = 0;
        chk("rlw_fetch", 32'(bus0.state), 0);
        tick(); wr_cnt += int'(bus0.regwrite);
        tick(); wr_cnt += int'(bus0.regwrite);
        tick(); chk("rlw_memrd", 32'(bus0.state), 3);
        wr_cnt += int'(bus0.regwrite);
        reset = 1'b1;
        #1;
        chk("rlw_rst_en", 32'({bus0.pcen, bus0.irwrite, bus0.regwrite, bus0.memwrite}), 0);
        tick(); chk("rlw_state", 32'(bus0.state), 0);
        wr_cnt += int'(bus0.regwrite);
        reset = 1'b0;
        set_op(6'b000000, 6'b100000);
        #1;
        wr_cnt += int'(bus0.regwrite);
        chk("rlw_no_regwrite", 32'(wr_cnt), 0);
        chk("rlw_fetch_en", 32'({bus0.irwrite, bus0.pcen}), 3);
        run_rtype(6'b100000, 3'b010);
        chk("rlw_final", 32'(bus0.state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle MIPS datapath inside `cpu`. It sits directly upstream of the datapath's PC, IR, register-file, memory and ALU steering.
- It is a Moore FSM that sequences each instruction through fetch, decode and execute/writeback states.
- It also contains the ALU decoder and the PC-enable logic for taken branches.
- Its cycle counts set the per-instruction latencies: lw 5, sw/R-type/addi 4, beq/bne/j 3.

Parameters:
- `ALUCTL_W`, 3, width of the ALU control code.
- `ILLEGAL_TRAP`, 0: 0 means an illegal opcode returns to FETCH; 1 means the FSM parks in HALT until reset.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU zero flag, combinational from the datapath.
- `pcen`  out  1  PC register enable.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  instruction-register load.
- `regwrite`  out  1  register-file write.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memtoreg`  out  1  write-back data select: 1 = Data register.
- `regdst`  out  1  destination select: 1 = rd, 0 = rt.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A register.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  `ALUCTL_W`  ALU operation code.
- `state`  out  4  current state, for debug and bench observation.
- `illegal`  out  1  high while in HALT, or for the DECODE cycle that saw an illegal opcode.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15.
- Reset: at a clock edge with `reset`=1, state becomes FETCH.
  - While `reset` is high, `pcen`, `memwrite`, `irwrite`, `regwrite` and `illegal` are forced to 0. All other outputs take their FETCH values.
  - Reset wins over any transition, including mid-instruction. No partial writes occur in the reset cycle.
  - The first cycle after reset deasserts is FETCH, and it performs a full fetch.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> EXECUTE.
    - beq 000100 or bne 000101 -> BRANCH.
    - addi 001000 -> ADDIEX.
    - j 000010 -> JUMP.
    - Any other opcode -> FETCH (`ILLEGAL_TRAP`=0) or HALT (`ILLEGAL_TRAP`=1).
  - MEMADR -> MEMRD for lw, MEMWR for sw. The opcode is re-read from `op`; the IR is stable because `irwrite`=0.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
  - HALT -> HALT.
- Outputs per state. Every signal not listed is 0 and `alusrcb`=00.
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01, aluop=00.
  - DECODE: `alusrcb`=11, aluop=00.
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=00.
  - MEMRD: `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - EXECUTE: `alusrca`=1, aluop=10.
  - ALUWB: `regwrite`=1, `regdst`=1.
  - ADDIWB: `regwrite`=1.
  - BRANCH: `alusrca`=1, aluop=01, `pcsrc`=01, branch=1, bne=(op==000101).
  - JUMP: `pcsrc`=10, `pcwrite`=1.
  - HALT: `illegal`=1, all enables 0.
- PC enable: `pcen` = `pcwrite` | (branch & (`zero` ^ bne)). This is combinational within the BRANCH cycle.
- ALU decoder (combinational):
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (sub).
  - aluop 10 decodes `funct`: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other `funct` -> 010.
- `state` and all controls are Moore outputs, valid throughout the cycle. The only Mealy path is `zero` -> `pcen` in BRANCH.

Test Plan:
- Reset held for 2 cycles, then R-type add (op=000000, funct=100000):
  - During reset: `state`=0 and `pcen`=`irwrite`=`regwrite`=`memwrite`=0.
  - After reset: `state` sequence 0,1,6,7,0.
  - `alucontrol`=010 in EXECUTE.
  - `regwrite`=1 and `regdst`=1 only in ALUWB.
- lw, then sw:
  - lw: `state` 0,1,2,3,4 (5 cycles); `iord`=1 in MEMRD; `memtoreg`=1 and `regwrite`=1 in MEMWB.
  - sw: `state` 0,1,2,5 (4 cycles); `memwrite`=1 for exactly one cycle.
- beq, 3 cycles each (`state` 0,1,8):
  - `zero`=0: `pcen`=0 in BRANCH.
  - `zero`=1: `pcen`=1 and `pcsrc`=01.
  - bne with `zero`=0: `pcen`=1.
  - `alucontrol`=110 in BRANCH.
- addi, then j:
  - addi: `state` 0,1,9,10 with `regwrite`=1 and `regdst`=0 in ADDIWB.
  - j: `state` 0,1,11 with `pcen`=1 and `pcsrc`=10.
- Illegal op=111111:
  - `ILLEGAL_TRAP`=0: DECODE -> FETCH, with `illegal`=1 in DECODE.
  - `ILLEGAL_TRAP`=1: `state`=15 held with `illegal`=1, until reset returns `state`=0.
- `reset` asserted in MEMRD of a lw:
  - Next `state`=0.
  - `regwrite` is never asserted for that lw.
  - The following fetch proceeds normally.
